param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
Parametrised successor of the single-cycle core's 32x32 register file. It adds configurable width and depth, a hardwired zero register, and write-to-read bypass. It also adds a synchronous sequential clear after reset, with a ready flag, and a per-register busy scoreboard for the pipelined datapath. A single debug read port replaces the per-register output bus. It sits between decode (read/alloc) and writeback (write) stages.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (2..64, need not be power of two)
AW, $clog2(NREGS), address width (derived, not overridden)
ZERO_REG, 1, 1 = register 0 reads 0, writes to it discarded
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
CLEAR_ON_RESET, 1, 1 = sequential zero-clear of all registers after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
rd_addr1  in  AW  read port 1 address
rd_addr2  in  AW  read port 2 address
rd_data1  out  XLEN  read port 1 data (combinational)
rd_data2  out  XLEN  read port 2 data (combinational)
rd_busy1  out  1  scoreboard busy flag for rd_addr1
rd_busy2  out  1  scoreboard busy flag for rd_addr2
wr_en  in  1  write enable (writeback)
wr_addr  in  AW  write address
wr_data  in  XLEN  write data
alloc_en  in  1  mark destination pending (decode)
alloc_addr  in  AW  destination to mark busy
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data (combinational, no bypass)
ready  out  1  1 = clear done, file accepts writes

Behaviour:
- States: CLEAR, READY.
- Reset, with reset=1 sampled at a clock edge:
  - state<=CLEAR, clr_idx<=0, ready<=0, all busy bits<=0.
  - Holding reset keeps clr_idx at 0.
- CLEAR_ON_RESET=1:
  - Each cycle in CLEAR with reset=0, reg[clr_idx]<=0 and clr_idx++.
  - After the edge that clears index NREGS-1, state<=READY, ready<=1.
  - ready therefore rises NREGS edges after the first edge with reset=0.
- CLEAR_ON_RESET=0: the first edge with reset=0 moves to READY. Register contents are left untouched (power-up X in sim).
- Reset asserted mid-clear restarts the clear at index 0.
- While ready=0:
  - wr_en and alloc_en are ignored.
  - rd_data1/2 and dbg_data output 0.
  - rd_busy1/2 output 0.
- Write, in READY: at the edge with wr_en=1, reg[wr_addr]<=wr_data and busy[wr_addr]<=0. The new value is visible on reads the following cycle.
- Read, combinational:
  - rd_dataN = reg[rd_addrN].
  - With BYPASS=1, if ready & wr_en & wr_addr==rd_addrN, then rd_dataN = wr_data. Both ports may bypass simultaneously.
- Zero register (ZERO_REG=1):
  - Reads of address 0 return 0, including the bypass path.
  - Writes to address 0 are dropped.
  - busy[0] is never set.
- Out-of-range addresses (>= NREGS):
  - Reads return 0 and busy reads 0.
  - Writes and allocs are ignored.
- Scoreboard:
  - alloc_en=1 at an edge sets busy[alloc_addr].
  - rd_busyN = busy[rd_addrN]. With BYPASS=1 it is masked to 0 when wr_en & wr_addr==rd_addrN, since the data is forwarded.
- Simultaneous alloc and write to the same address: set wins, busy=1 after the edge, and the data is still written.
- Alloc and write to different addresses update independently.
- dbg_data = reg[dbg_addr], with the zero/out-of-range rules applied and no bypass.
- Latency: reads 0 cycles; writes and scoreboard updates 1 cycle.

Test Plan:
- Reset 3 cycles then release (NREGS=32, CLEAR_ON_RESET=1) -> ready=0 for 32 edges, rises on the 32nd; dbg_data=0 for all 32 addresses; a write of 0xDEADBEEF to x5 during CLEAR is not stored.
- READY: write x7=0x12345678, rd_addr1=7 in the same cycle -> rd_data1=0x12345678 (bypass); next cycle without wr_en -> rd_data1=0x12345678 from storage. BYPASS=0 -> the same-cycle read shows the old value 0.
- Write x0=0xFFFFFFFF, alloc x0 -> rd_data1(addr 0)=0, rd_busy1=0, dbg_data(0)=0.
- Scoreboard on x9: alloc x9 -> rd_busy2=1 next cycle; write x9=0xA5 -> rd_busy2=0 in that cycle (masked) and after the edge. Simultaneous alloc+write x9=0x5A -> busy=1, dbg_data(9)=0x5A.
- Reset asserted at clr_idx=10 -> clr_idx returns to 0; ready rises only 32 edges after release.
- NREGS=24: write addr 30 -> ignored; read addr 30 -> 0, busy 0; ready rises after 24 edges.

Source files
------------

// File: rtl/param_register_file.sv
// param_register_file: parametrised register file with a hardwired zero
// register, write-to-read bypass, a sequential zero-clear after reset that
// gates a ready flag, and a per-register busy scoreboard for the pipeline.
module param_register_file #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter bit ZERO_REG       = 1'b1,
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW            = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            rd_busy1,
  output logic            rd_busy2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            ready
);

  localparam int AWP = AW + 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic              mem_we_s;
  logic [AW-1:0]     mem_addr_s;
  logic [XLEN-1:0]   mem_wdata_s;

  // An address names real, modifiable storage: in range and not the
  // hardwired zero register. Reads of anything else return 0.
  function automatic logic addr_live(input logic [AW-1:0] addr);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, addr} < AWP'(NREGS));
    is_zero  = ZERO_REG && (addr == {AW{1'b0}});
    return in_range && !is_zero;
  endfunction

  // A write on the same cycle to the address being read is forwarded.
  function automatic logic bypass_hit(input logic [AW-1:0] addr);
    return BYPASS && ready_q && wr_en && (wr_addr == addr);
  endfunction

  function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] addr,
                                                input logic          use_bypass);
    logic [XLEN-1:0] val;
    if (!ready_q || !addr_live(addr)) begin
      val = {XLEN{1'b0}};
    end else if (use_bypass && bypass_hit(addr)) begin
      val = wr_data;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  // Busy is hidden once the producing write is being forwarded this cycle.
  function automatic logic read_busy(input logic [AW-1:0] addr);
    logic val;
    if (!ready_q || !addr_live(addr)) begin
      val = 1'b0;
    end else if (bypass_hit(addr)) begin
      val = 1'b0;
    end else begin
      val = busy_q[addr];
    end
    return val;
  endfunction

  // Next-state for the clear sequencer, ready flag, scoreboard and storage write port.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = wr_addr;
    mem_wdata_s = wr_data;
    if (reset) begin
      state_d   = ST_CLEAR;
      clr_idx_d = {AW{1'b0}};
      ready_d   = 1'b0;
      busy_d    = {NREGS{1'b0}};
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (CLEAR_ON_RESET) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_idx_q;
            mem_wdata_s = {XLEN{1'b0}};
            if (clr_idx_q == AW'(NREGS - 1)) begin
              state_d   = ST_READY;
              ready_d   = 1'b1;
              clr_idx_d = {AW{1'b0}};
            end else begin
              clr_idx_d = clr_idx_q + AW'(1);
            end
          end else begin
            state_d = ST_READY;
            ready_d = 1'b1;
          end
        end
        ST_READY: begin
          // Clear-on-write first so a same-edge alloc to the same register wins.
          if (wr_en && addr_live(wr_addr)) begin
            mem_we_s        = 1'b1;
            busy_d[wr_addr] = 1'b0;
          end else begin
            mem_we_s = 1'b0;
          end
          if (alloc_en && addr_live(alloc_addr)) begin
            busy_d[alloc_addr] = 1'b1;
          end else begin
            busy_d = busy_d;
          end
        end
        default: begin
          state_d   = ST_CLEAR;
          clr_idx_d = {AW{1'b0}};
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // Control registers: sequencer state, clear index, ready flag, scoreboard.
  always_ff @(posedge clock) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    ready_q   <= ready_d;
    busy_q    <= busy_d;
  end

  // Register storage; not reset directly, zeroed by the clear sequence.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      regs_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign rd_data1 = read_data(rd_addr1, 1'b1);
  assign rd_data2 = read_data(rd_addr2, 1'b1);
  assign dbg_data = read_data(dbg_addr, 1'b0);
  assign rd_busy1 = read_busy(rd_addr1);
  assign rd_busy2 = read_busy(rd_addr2);
  assign ready    = ready_q;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three configurations (default, no bypass,
// 24 registers) share one stimulus stream; a behavioural model per config is
// compared against every output on every negative clock edge, plus directed
// literal checks for the main scenarios.
module tb_param_register_file;
  localparam int AW   = 5;
  localparam int NCFG = 3;

  logic          clock;
  logic          reset;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, alloc_addr, dbg_addr;
  logic          wr_en, alloc_en;
  logic [31:0]   wr_data;

  logic [31:0]   rd1 [NCFG];
  logic [31:0]   rd2 [NCFG];
  logic [31:0]   dbg [NCFG];
  logic          b1  [NCFG];
  logic          b2  [NCFG];
  logic          rdy [NCFG];

  int checks = 0;
  int fails  = 0;
  bit check_en = 1'b0;

  int n_m   [NCFG] = '{32, 32, 24};
  bit byp_m [NCFG] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_mem  [NCFG][64];
  bit          m_busy [NCFG][64];
  bit          m_rdy  [NCFG];
  int          m_cnt  [NCFG];

  param_register_file #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)) u_dut_a (
    .clock(clock), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1[0]), .rd_data2(rd2[0]), .rd_busy1(b1[0]), .rd_busy2(b2[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .dbg_addr(dbg_addr), .dbg_data(dbg[0]), .ready(rdy[0]));

  param_register_file #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)) u_dut_b (
    .clock(clock), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1[1]), .rd_data2(rd2[1]), .rd_busy1(b1[1]), .rd_busy2(b2[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .dbg_addr(dbg_addr), .dbg_data(dbg[1]), .ready(rdy[1]));

  param_register_file #(.XLEN(32), .NREGS(24), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)) u_dut_c (
    .clock(clock), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1[2]), .rd_data2(rd2[2]), .rd_busy1(b1[2]), .rd_busy2(b2[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .dbg_addr(dbg_addr), .dbg_data(dbg[2]), .ready(rdy[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_rd(input int k, input logic [AW-1:0] a, input bit fwd);
    if (!m_rdy[k] || int'(a) >= n_m[k] || a == 5'd0) return 32'd0;
    if (fwd && byp_m[k] && wr_en && wr_addr == a) return wr_data;
    return m_mem[k][a];
  endfunction

  function automatic logic [31:0] exp_busy(input int k, input logic [AW-1:0] a);
    if (!m_rdy[k] || int'(a) >= n_m[k] || a == 5'd0) return 32'd0;
    if (byp_m[k] && wr_en && wr_addr == a) return 32'd0;
    return {31'd0, m_busy[k][a]};
  endfunction

  // Behavioural model: advance architectural state at each rising edge.
  always @(posedge clock) begin
    for (int k = 0; k < NCFG; k++) begin
      if (reset) begin
        m_rdy[k] = 1'b0;
        m_cnt[k] = 0;
        for (int j = 0; j < 64; j++) m_busy[k][j] = 1'b0;
      end else if (!m_rdy[k]) begin
        m_mem[k][m_cnt[k]] = 32'd0;
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == n_m[k]) m_rdy[k] = 1'b1;
      end else begin
        if (wr_en && int'(wr_addr) < n_m[k] && wr_addr != 5'd0) begin
          m_mem[k][wr_addr] = wr_data;
          m_busy[k][wr_addr] = 1'b0;
        end
        if (alloc_en && int'(alloc_addr) < n_m[k] && alloc_addr != 5'd0)
          m_busy[k][alloc_addr] = 1'b1;
      end
    end
  end

  // Compare every output of every configuration against the model.
  always @(negedge clock) begin
    if (check_en) begin
      for (int k = 0; k < NCFG; k++) begin
        chk($sformatf("cfg%0d ready", k),    {31'd0, rdy[k]}, {31'd0, m_rdy[k]});
        chk($sformatf("cfg%0d rd_data1", k), rd1[k], exp_rd(k, rd_addr1, 1'b1));
        chk($sformatf("cfg%0d rd_data2", k), rd2[k], exp_rd(k, rd_addr2, 1'b1));
        chk($sformatf("cfg%0d dbg_data", k), dbg[k], exp_rd(k, dbg_addr, 1'b0));
        chk($sformatf("cfg%0d rd_busy1", k), {31'd0, b1[k]}, exp_busy(k, rd_addr1));
        chk($sformatf("cfg%0d rd_busy2", k), {31'd0, b2[k]}, exp_busy(k, rd_addr2));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    alloc_en = 1'b0;
  endtask

  // Count edges from release to ready; a write to x5 is attempted during the clear.
  task automatic release_and_count(input string tag);
    int rise [NCFG];
    for (int k = 0; k < NCFG; k++) rise[k] = 0;
    reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 3) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      for (int k = 0; k < NCFG; k++)
        if (rdy[k] === 1'b1 && rise[k] == 0) rise[k] = n;
    end
    idle();
    chk({tag, " ready edge cfg0"}, rise[0], 32'd32);
    chk({tag, " ready edge cfg1"}, rise[1], 32'd32);
    chk({tag, " ready edge cfg2"}, rise[2], 32'd24);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; alloc_en = 1'b0; wr_data = 32'd0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0; wr_addr = 5'd0; alloc_addr = 5'd0; dbg_addr = 5'd0;
    repeat (3) tick();
    check_en = 1'b1;
    @(negedge clock);
    for (int k = 0; k < NCFG; k++) chk("ready in reset", {31'd0, rdy[k]}, 32'd0);
    tick();
    release_and_count("first clear");

    // Every register reads zero after the clear, including x5 written during CLEAR.
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[AW-1:0];
      @(negedge clock);
      chk("post-clear dbg cfg0", dbg[0], 32'd0);
      chk("post-clear dbg cfg1", dbg[1], 32'd0);
      tick();
    end

    // Same-cycle bypass versus storage.
    rd_addr1 = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    @(negedge clock);
    chk("x7 bypass", rd1[0], 32'h12345678);
    chk("x7 no-bypass old", rd1[1], 32'd0);
    tick(); idle();
    @(negedge clock);
    chk("x7 stored", rd1[0], 32'h12345678);
    chk("x7 stored nobyp", rd1[1], 32'h12345678);

    // Zero register ignores writes and allocs.
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr1 = 5'd0; dbg_addr = 5'd0;
    @(negedge clock);
    chk("x0 bypass data", rd1[0], 32'd0);
    chk("x0 busy", {31'd0, b1[0]}, 32'd0);
    tick(); idle();
    @(negedge clock);
    chk("x0 data", rd1[0], 32'd0);
    chk("x0 busy after", {31'd0, b1[0]}, 32'd0);
    chk("x0 dbg", dbg[0], 32'd0);

    // Scoreboard on x9.
    tick();
    alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr2 = 5'd9;
    tick(); idle();
    @(negedge clock);
    chk("x9 busy after alloc", {31'd0, b2[0]}, 32'd1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h000000A5;
    @(negedge clock);
    chk("x9 busy masked", {31'd0, b2[0]}, 32'd0);
    chk("x9 fwd data", rd2[0], 32'h000000A5);
    chk("x9 busy nobyp", {31'd0, b2[1]}, 32'd1);
    tick(); idle();
    @(negedge clock);
    chk("x9 busy after write", {31'd0, b2[0]}, 32'd0);
    chk("x9 data", rd2[0], 32'h000000A5);
    tick();
    alloc_en = 1'b1; alloc_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000005A; dbg_addr = 5'd9;
    tick(); idle();
    @(negedge clock);
    chk("x9 alloc+write busy", {31'd0, b2[0]}, 32'd1);
    chk("x9 alloc+write dbg", dbg[0], 32'h0000005A);

    // Out-of-range address on the 24-register file.
    tick();
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h00000011; alloc_en = 1'b1; alloc_addr = 5'd30;
    tick(); idle();
    rd_addr1 = 5'd30; dbg_addr = 5'd30;
    @(negedge clock);
    chk("n24 addr30 data", rd1[2], 32'd0);
    chk("n24 addr30 busy", {31'd0, b1[2]}, 32'd0);
    chk("n24 addr30 dbg", dbg[2], 32'd0);
    chk("n32 addr30 data", rd1[0], 32'h00000011);
    chk("n32 addr30 busy", {31'd0, b1[0]}, 32'd1);

    // Reset mid-clear at index 10 restarts the sequence.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    chk("mid-clear reset ready", {31'd0, rdy[0]}, 32'd0);
    tick();
    release_and_count("restart clear");

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      tick();
      reset      = ($urandom_range(0, 199) == 0);
      rd_addr1   = 5'($urandom_range(0, 31));
      rd_addr2   = 5'($urandom_range(0, 31));
      dbg_addr   = 5'($urandom_range(0, 31));
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
      wr_data    = $urandom;
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = ($urandom_range(0, 3) == 0) ? rd_addr2 : 5'($urandom_range(0, 31));
    end
    tick();
    reset = 1'b0; idle();
    tick();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
